alu_seq_ctrl: RTL and testbench

Sequential command front-end for the W-bit combinational ALU: accepts one operation per valid/ready handshake, reads operands from a 4-entry register file (or an immediate), drives the ALU's A/B/control inputs, and writes the ALU result back to the register file. It latches the ALU's co/ovf/z/n outputs into a persistent NZCV flag register and returns each result on a valid/ready response channel. The ALU itself stays purely combinational. This block supplies the ALU's operands and consumes its outputs.

---
 rtl/alu_seq_ctrl_if.sv | 52 +++++
 rtl/alu_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_alu_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl_if
// Description : Command, ALU-side and response channels of alu_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_ctrl_if #(
    parameter int W = 8
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [1:0]   cmd_rd;
    logic [1:0]   cmd_rs1;
    logic [1:0]   cmd_rs2;
    logic         cmd_imm_en;
    logic [W-1:0] cmd_imm;
    logic         cmd_setflags;

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_control;
    logic [W-1:0] alu_out;
    logic         alu_co;
    logic         alu_ovf;
    logic         alu_z;
    logic         alu_n;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic [3:0]   rsp_flags;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm, cmd_setflags,
        output cmd_ready,
        output alu_a, alu_b, alu_control,
        input  alu_out, alu_co, alu_ovf, alu_z, alu_n,
        output rsp_valid, rsp_data, rsp_flags,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm, cmd_setflags,
        input  cmd_ready,
        input  alu_a, alu_b, alu_control,
        output alu_out, alu_co, alu_ovf, alu_z, alu_n,
        input  rsp_valid, rsp_data, rsp_flags,
        output rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Sequential command front-end with 4-entry register file and
//               NZCV flag register around an external combinational ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    alu_seq_ctrl_if.slave     bus,
    output logic [3:0]        flags,
    input  wire logic [1:0]   dbg_addr,
    output logic [W-1:0]      dbg_data
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_EXEC   = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;
    localparam logic [2:0] c_OP_CLR = 3'd5;
    localparam logic [2:0] c_OP_LDI = 3'd7;

    logic [1:0]   r_state;
    logic [1:0]   w_state_next;
    logic [W-1:0] r_regs [4];
    logic [W-1:0] r_alu_a;
    logic [W-1:0] r_alu_b;
    logic [2:0]   r_alu_control;
    logic [1:0]   r_rd;
    logic         r_setflags;
    logic         r_is_ldi;
    logic         r_rsp_valid;
    logic [W-1:0] r_rsp_data;
    logic [3:0]   r_rsp_flags;
    logic [3:0]   r_flags;
    logic         w_accept;
    logic         w_rsp_done;
    logic [W-1:0] w_result;
    logic [3:0]   w_alu_flags;

    assign w_accept    = bus.cmd_valid && (r_state == c_IDLE);
    assign w_rsp_done  = r_rsp_valid && bus.rsp_ready;
    // For LDI the immediate already sits in r_alu_b, so it doubles as the write value.
    assign w_result    = r_is_ldi ? r_alu_b : bus.alu_out;
    assign w_alu_flags = {bus.alu_n, bus.alu_z, bus.alu_co, bus.alu_ovf};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_accept)   w_state_next = c_EXEC;
            c_EXEC:                  w_state_next = c_RESP;
            c_RESP:  if (w_rsp_done) w_state_next = c_IDLE;
            default:                 w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_control <= '0;
            r_rd          <= '0;
            r_setflags    <= 1'b0;
            r_is_ldi      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_flags   <= '0;
            r_flags       <= '0;
        end else begin
            if (w_accept) begin
                r_rd       <= bus.cmd_rd;
                r_setflags <= bus.cmd_setflags;
                if (bus.cmd_op == c_OP_LDI) begin
                    r_is_ldi      <= 1'b1;
                    r_alu_a       <= '0;
                    r_alu_b       <= bus.cmd_imm;
                    r_alu_control <= c_OP_CLR;
                end else begin
                    r_is_ldi      <= 1'b0;
                    r_alu_a       <= r_regs[bus.cmd_rs1];
                    r_alu_b       <= bus.cmd_imm_en ? bus.cmd_imm : r_regs[bus.cmd_rs2];
                    r_alu_control <= bus.cmd_op;
                end
            end
            if (r_state == c_EXEC) begin
                r_regs[r_rd] <= w_result;
                r_rsp_data   <= w_result;
                r_rsp_flags  <= r_is_ldi ? 4'b0000 : w_alu_flags;
                if (r_setflags && !r_is_ldi) begin
                    r_flags <= w_alu_flags;
                end
                r_rsp_valid  <= 1'b1;
            end else if (w_rsp_done) begin
                r_rsp_valid  <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready   = (r_state == c_IDLE);
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_control = r_alu_control;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_flags   = r_rsp_flags;
    assign flags           = r_flags;
    assign dbg_data        = r_regs[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_ctrl
// Description : Directed and randomized self-checking bench for alu_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   flags;
    logic [1:0]   dbg_addr;
    logic [W-1:0] dbg_data;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           last_rsp_cyc = 0;
    logic [7:0]   m_regs [4];
    logic [3:0]   m_flags;

    alu_seq_ctrl_if #(.W(W)) bus ();

    alu_seq_ctrl #(.W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .flags    (flags),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational ALU stand-in driven by the DUT's operand registers.
    logic [8:0] w_sum;
    logic [7:0] w_o;
    logic       w_ov;
    always_comb begin
        w_sum = '0;
        w_o   = '0;
        w_ov  = 1'b0;
        case (bus.alu_control)
            3'd0: begin
                w_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                w_o   = w_sum[7:0];
                w_ov  = (bus.alu_a[7] == bus.alu_b[7]) && (w_o[7] != bus.alu_a[7]);
            end
            3'd1: begin
                w_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 9'd1;
                w_o   = w_sum[7:0];
                w_ov  = (bus.alu_a[7] != bus.alu_b[7]) && (w_o[7] != bus.alu_a[7]);
            end
            3'd2:    w_o = bus.alu_a & bus.alu_b;
            3'd3:    w_o = bus.alu_a | bus.alu_b;
            3'd4:    w_o = bus.alu_a ^ bus.alu_b;
            3'd6:    w_o = bus.alu_a;
            default: w_o = '0;
        endcase
        bus.alu_out = w_o;
        bus.alu_co  = w_sum[8];
        bus.alu_ovf = w_ov;
        bus.alu_z   = (w_o == 8'h00);
        bus.alu_n   = w_o[7] & ~w_ov;
    end

    // Reference: {n,z,c,v,result} from integer arithmetic on the command itself.
    function automatic logic [11:0] ref_op(input int op, input int a, input int b, input int imm);
        int r, sa, sb, sr;
        bit c, v, n, z;
        logic [7:0] res;
        c = 0; v = 0; r = 0;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        case (op)
            0: begin r = a + b; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
            1: begin r = a - b; c = (a >= b);  sr = sa - sb; v = (sr > 127) || (sr < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 0;
            6: r = a;
            default: r = imm;
        endcase
        res = 8'(r & 255);
        if (op == 7) return {4'b0000, res};
        z = (res == 8'h00);
        n = (res > 8'd127) && !v;
        return {n, z, c, v, res};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            check(tag, dbg_data, m_regs[i]);
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                           input logic [1:0] rs2, input logic imm_en, input logic [7:0] imm,
                           input logic sf, input int stall, input bit poke);
        logic [11:0] e;
        logic [7:0]  b;
        logic [1:0]  pr;
        int          n;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_ready_wait", bus.cmd_ready, 1);
        bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2;
        bus.cmd_imm_en = imm_en; bus.cmd_imm = imm; bus.cmd_setflags = sf;
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = (stall == 0);
        b = imm_en ? imm : m_regs[rs2];
        e = ref_op(int'(op), int'(m_regs[rs1]), int'(b), int'(imm));
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 3'($urandom); bus.cmd_imm = 8'($urandom); bus.cmd_rs1 = 2'($urandom);
        check("exec_cmd_ready", bus.cmd_ready, 0);
        check("exec_rsp_valid", bus.rsp_valid, 0);
        m_regs[rd] = e[7:0];
        if (sf && op != 3'd7) m_flags = e[11:8];
        @(posedge clk); #1;
        last_rsp_cyc = cyc;
        check("rsp_valid", bus.rsp_valid, 1);
        check("rsp_data", bus.rsp_data, e[7:0]);
        check("rsp_flags", bus.rsp_flags, e[11:8]);
        check("flags", flags, m_flags);
        pr = rd + 2'd1;
        for (int i = 0; i < stall; i++) begin
            if (poke && i == 1) begin
                bus.cmd_op = 3'd7; bus.cmd_rd = pr; bus.cmd_imm = ~m_regs[pr];
                bus.cmd_valid = 1'b1;
            end
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            check("stall_rsp_valid", bus.rsp_valid, 1);
            check("stall_rsp_data", bus.rsp_data, e[7:0]);
            check("stall_cmd_ready", bus.cmd_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rsp_valid", bus.rsp_valid, 0);
        check("post_cmd_ready", bus.cmd_ready, 1);
        dbg_addr = rd; #1;
        check("dbg_rd", dbg_data, m_regs[rd]);
        if (poke) begin
            dbg_addr = pr; #1;
            check("dbg_poke_ignored", dbg_data, m_regs[pr]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, c1, c2;
        reset = 1'b1;
        dbg_addr = '0;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_rs1 = '0;
        bus.cmd_rs2 = '0; bus.cmd_imm_en = 1'b0; bus.cmd_imm = '0; bus.cmd_setflags = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_flags = 4'h0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_flags", bus.rsp_flags, 0);
        check("rst_flags", flags, 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_alu_b", bus.alu_b, 0);
        check("rst_alu_control", bus.alu_control, 0);
        check_all_regs("rst_reg");

        // ADD overflow
        run_cmd(3'd7, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7F, 1'b0, 0, 0);
        run_cmd(3'd7, 2'd2, 2'd0, 2'd0, 1'b1, 8'h01, 1'b0, 0, 0);
        run_cmd(3'd0, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 1'b1, 0, 0);
        check("add_ovf_data", bus.rsp_data, 8'h80);
        check("add_ovf_rsp_flags", bus.rsp_flags, 4'b0001);
        check("add_ovf_flags", flags, 4'b0001);

        // SUB to zero via immediate
        run_cmd(3'd7, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 1'b0, 0, 0);
        run_cmd(3'd1, 2'd0, 2'd1, 2'd0, 1'b1, 8'h05, 1'b1, 0, 0);
        check("sub_zero_data", bus.rsp_data, 8'h00);
        check("sub_zero_rsp_flags", bus.rsp_flags, 4'b0110);

        // setflags=0 keeps the NZCV register
        run_cmd(3'd4, 2'd2, 2'd1, 2'd1, 1'b0, 8'h00, 1'b0, 0, 0);
        check("xor_rsp_flags", bus.rsp_flags, 4'b0100);
        check("xor_flags_kept", flags, 4'b0110);

        // Back-pressure with an ignored command poke
        run_cmd(3'd7, 2'd2, 2'd0, 2'd0, 1'b1, 8'hAA, 1'b0, 5, 1);

        // Back-to-back dependence chain
        run_cmd(3'd7, 2'd0, 2'd0, 2'd0, 1'b1, 8'hF0, 1'b0, 0, 0);
        c0 = last_rsp_cyc;
        check("chain_ldi", bus.rsp_data, 8'hF0);
        run_cmd(3'd2, 2'd0, 2'd0, 2'd0, 1'b1, 8'h3C, 1'b0, 0, 0);
        c1 = last_rsp_cyc;
        check("chain_and", bus.rsp_data, 8'h30);
        run_cmd(3'd3, 2'd0, 2'd0, 2'd0, 1'b1, 8'h01, 1'b0, 0, 0);
        c2 = last_rsp_cyc;
        check("chain_or", bus.rsp_data, 8'h31);
        check("chain_gap1", 32'(c1 - c0), 3);
        check("chain_gap2", 32'(c2 - c1), 3);

        // Randomized commands with random response stalls
        for (int k = 0; k < 40; k++) begin
            run_cmd(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                    8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 0);
        end

        // Reset during EXEC drops the command and clears state
        bus.cmd_op = 3'd0; bus.cmd_rd = 2'd3; bus.cmd_rs1 = 2'd0; bus.cmd_rs2 = 2'd1;
        bus.cmd_imm_en = 1'b0; bus.cmd_setflags = 1'b1; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check("midop_in_exec", bus.cmd_ready, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_flags = 4'h0;
        check("midop_rsp_valid", bus.rsp_valid, 0);
        check("midop_flags", flags, 0);
        check("midop_cmd_ready", bus.cmd_ready, 1);
        check_all_regs("midop_reg");
        @(posedge clk); #1;
        check("midop_no_rsp", bus.rsp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
